// File: rtl/line_sensor_pkg.sv
// Shared constants and state encoding for the line sensor processing slice.
package line_sensor_pkg;
  localparam int VAL_W = 12;
  localparam int ERR_W = 13;
  localparam int SUM_W = 14;

  localparam int DEF_SAMPLE_DIV = 50000;
  localparam logic [VAL_W-1:0] DEF_THRESH_HI = 12'd1500;
  localparam logic [VAL_W-1:0] DEF_THRESH_LO = 12'd1300;
  localparam int DEF_NODE_COUNT = 4;
  localparam int DEF_LOST_COUNT = 16;

  localparam logic [1:0] ST_FOLLOW = 2'd0;
  localparam logic [1:0] ST_NODE   = 2'd1;
  localparam logic [1:0] ST_LOST   = 2'd2;

  typedef enum logic [1:0] {
    FOLLOW = ST_FOLLOW,
    NODE   = ST_NODE,
    LOST   = ST_LOST
  } track_state_t;
endpackage

// File: rtl/line_channel_filter.sv
// One ADC channel: two-stage re-timing, 4-sample moving average, hysteresis bit.
module line_channel_filter
  import line_sensor_pkg::*;
#(
  parameter logic [VAL_W-1:0] THRESH_HI = DEF_THRESH_HI,
  parameter logic [VAL_W-1:0] THRESH_LO = DEF_THRESH_LO
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic [VAL_W-1:0] raw,
  input  logic             capture,
  output logic             stable,
  output logic [VAL_W-1:0] avg,
  output logic             on_line
);
  logic [VAL_W-1:0]         s1;
  logic [VAL_W-1:0]         s2;
  logic [3:0][VAL_W-1:0]    hist;
  logic [SUM_W-1:0]         sum;
  logic [SUM_W-1:0]         sum_next;
  logic [VAL_W-1:0]         avg_next;

  assign stable   = (s1 == s2);
  // Intermediate wrap is harmless: the final sum always fits in 14 bits.
  assign sum_next = sum + {2'b00, s2} - {2'b00, hist[3]};
  assign avg_next = sum_next[SUM_W-1:2];
  assign avg      = sum[SUM_W-1:2];

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      hist    <= '0;
      sum     <= '0;
      on_line <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (capture) begin
        hist <= {hist[2:0], s2};
        sum  <= sum_next;
        // Threshold the new average on the capture edge so the bit is ready with avg.
        if (avg_next >= THRESH_HI) begin
          on_line <= 1'b1;
        end else if (avg_next < THRESH_LO) begin
          on_line <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/line_sensor_processor.sv
// Sample-rate capture, error subtractor and node/line-loss tracking over three channels.
module line_sensor_processor
  import line_sensor_pkg::*;
#(
  parameter int               SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter logic [VAL_W-1:0] THRESH_HI  = DEF_THRESH_HI,
  parameter logic [VAL_W-1:0] THRESH_LO  = DEF_THRESH_LO,
  parameter int               NODE_COUNT = DEF_NODE_COUNT,
  parameter int               LOST_COUNT = DEF_LOST_COUNT
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [11:0]       left_value,
  input  logic [11:0]       center_value,
  input  logic [11:0]       right_value,
  output logic [2:0]        line_pattern,
  output logic signed [12:0] position_error,
  output logic              sample_valid,
  output logic              node_detected,
  output logic              line_lost,
  output logic [7:0]        node_count,
  output logic [1:0]        fsm_state
);
  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam int RUN_W = 8;
  localparam logic [RUN_W-1:0] NODE_N  = RUN_W'(NODE_COUNT);
  localparam logic [RUN_W-1:0] LOST_N  = RUN_W'(LOST_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              pending;
  logic              capture;
  logic              cap_d1;
  logic [2:0]        fill;
  logic              valid_now;
  logic              all_stable;
  logic              l_stable, c_stable, r_stable;
  logic              l_on, c_on, r_on;
  logic [VAL_W-1:0]  l_avg, r_avg;
  logic [2:0]        pattern;
  logic [RUN_W-1:0]  ones_run, ones_next;
  logic [RUN_W-1:0]  zeros_run, zeros_next;
  logic              node_hit;
  track_state_t      state, state_next;

  line_channel_filter #(.THRESH_HI(THRESH_HI), .THRESH_LO(THRESH_LO)) u_left (
    .clk_50M(clk_50M), .reset(reset), .raw(left_value), .capture(capture),
    .stable(l_stable), .avg(l_avg), .on_line(l_on)
  );
  line_channel_filter #(.THRESH_HI(THRESH_HI), .THRESH_LO(THRESH_LO)) u_center (
    .clk_50M(clk_50M), .reset(reset), .raw(center_value), .capture(capture),
    .stable(c_stable), .avg(), .on_line(c_on)
  );
  line_channel_filter #(.THRESH_HI(THRESH_HI), .THRESH_LO(THRESH_LO)) u_right (
    .clk_50M(clk_50M), .reset(reset), .raw(right_value), .capture(capture),
    .stable(r_stable), .avg(r_avg), .on_line(r_on)
  );

  assign all_stable = l_stable & c_stable & r_stable;
  assign tick       = (tick_cnt == TICK_LAST);
  // A tick waits in pending until all channels agree; overlapping ticks merge into one capture.
  assign capture    = (tick | pending) & all_stable;
  assign valid_now  = cap_d1 & (fill == 3'd4);
  assign pattern    = {l_on, c_on, r_on};
  assign line_lost  = (state == LOST);
  assign fsm_state  = state;

  always_comb begin
    state_next = state;
    ones_next  = ones_run;
    zeros_next = zeros_run;
    node_hit   = 1'b0;
    if (valid_now) begin
      ones_next  = (pattern != 3'b111) ? '0 : (ones_run == NODE_N) ? ones_run : ones_run + RUN_ONE;
      zeros_next = (pattern != 3'b000) ? '0 : (zeros_run == LOST_N) ? zeros_run : zeros_run + RUN_ONE;
      case (state)
        FOLLOW: begin
          if (ones_next == NODE_N) begin
            state_next = NODE;
            node_hit   = 1'b1;
          end else if (zeros_next == LOST_N) begin
            state_next = LOST;
          end
        end
        NODE: begin
          if (zeros_next == LOST_N) state_next = LOST;
          else if (pattern != 3'b111) state_next = FOLLOW;
        end
        LOST:    if (pattern != 3'b000) state_next = FOLLOW;
        default: state_next = FOLLOW;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      tick_cnt       <= '0;
      pending        <= 1'b0;
      cap_d1         <= 1'b0;
      fill           <= '0;
      sample_valid   <= 1'b0;
      node_detected  <= 1'b0;
      line_pattern   <= '0;
      position_error <= '0;
      ones_run       <= '0;
      zeros_run      <= '0;
      node_count     <= '0;
      state          <= FOLLOW;
    end else begin
      tick_cnt      <= tick ? '0 : tick_cnt + TICK_W'(1);
      pending       <= (tick | pending) & ~all_stable;
      cap_d1        <= capture;
      sample_valid  <= valid_now;
      node_detected <= node_hit;
      ones_run      <= ones_next;
      zeros_run     <= zeros_next;
      state         <= state_next;
      if (capture && fill != 3'd4) fill <= fill + 3'd1;
      if (valid_now) begin
        line_pattern   <= pattern;
        position_error <= $signed({1'b0, r_avg}) - $signed({1'b0, l_avg});
      end
      if (node_hit && node_count != 8'hFF) node_count <= node_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_line_sensor_processor.sv
// Directed bench for line_sensor_processor with a shortened sample period.
module tb_line_sensor_processor;
  import line_sensor_pkg::*;

  localparam int DIV = 16;

  logic              clk_50M = 1'b0;
  logic              reset;
  logic [11:0]       left_value, center_value, right_value;
  logic [2:0]        line_pattern;
  logic signed [12:0] position_error;
  logic              sample_valid, node_detected, line_lost;
  logic [7:0]        node_count;
  logic [1:0]        fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc, pulses, pulse_at, bad_reps, win, toggled_valids;
  logic lost_seen;

  always #10 clk_50M = ~clk_50M;

  line_sensor_processor #(.SAMPLE_DIV(DIV)) dut (
    .clk_50M(clk_50M), .reset(reset),
    .left_value(left_value), .center_value(center_value), .right_value(right_value),
    .line_pattern(line_pattern), .position_error(position_error),
    .sample_valid(sample_valid), .node_detected(node_detected),
    .line_lost(line_lost), .node_count(node_count), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where sample_valid is high; n = negedges waited.
  task automatic wait_valid(output int n);
    n = 1;
    @(negedge clk_50M);
    while (sample_valid !== 1'b1 && n < 200) begin
      @(negedge clk_50M);
      n++;
    end
    checks++;
    assert (sample_valid === 1'b1) else begin
      errors++;
      $error("FAIL wait_valid: observed=%b expected=1 after %0d cycles", sample_valid, n);
    end
  endtask

  task automatic set_in(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    left_value   = l;
    center_value = c;
    right_value  = r;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pattern"}, line_pattern, 0);
    check({tag, "_error"}, position_error, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_node"}, node_detected, 0);
    check({tag, "_lost"}, line_lost, 0);
    check({tag, "_count"}, node_count, 0);
    check({tag, "_state"}, fsm_state, ST_FOLLOW);
  endtask

  initial begin
    // Reset with all channels at 2000
    reset = 1'b1;
    set_in(12'd2000, 12'd2000, 12'd2000);
    repeat (3) @(negedge clk_50M);
    check_all_zero("reset");
    reset = 1'b0;

    // First three captures are suppressed; 4th capture lands 65 cycles after release
    wait_valid(cyc);
    check("fill_latency", cyc, 65);
    check("fill_pattern", line_pattern, 3'b111);
    check("fill_error", position_error, 0);
    pulses = 0;
    pulse_at = 0;
    if (node_detected) begin pulses++; pulse_at = 1; end
    for (int i = 2; i <= 10; i++) begin
      wait_valid(cyc);
      if (node_detected) begin pulses++; pulse_at = i; end
    end
    check("node_pulses", pulses, 1);
    check("node_pulse_sample", pulse_at, 4);
    check("node_count_1", node_count, 1);
    check("node_state", fsm_state, ST_NODE);

    // 010: left/right averages drop 2000 -> 1500 (still set) -> 1000 (cleared)
    set_in(12'd0, 12'd2000, 12'd0);
    wait_valid(cyc);
    check("n2f_s1_pattern", line_pattern, 3'b111);
    check("n2f_s1_state", fsm_state, ST_NODE);
    wait_valid(cyc);
    check("n2f_s2_pattern", line_pattern, 3'b010);
    check("n2f_s2_state", fsm_state, ST_FOLLOW);
    repeat (2) wait_valid(cyc);
    check("n2f_error", position_error, 0);
    check("n2f_count", node_count, 1);

    // Lost: pattern 010 for one sample, then 000 from sample 2; 16th zero is sample 17
    set_in(12'd0, 12'd0, 12'd0);
    for (int i = 1; i <= 17; i++) begin
      wait_valid(cyc);
      if (i == 1) check("lost_s1_pattern", line_pattern, 3'b010);
      if (i == 2) check("lost_s2_pattern", line_pattern, 3'b000);
      if (i == 16) check("lost_s16_low", line_lost, 0);
      if (i == 17) check("lost_s17_high", line_lost, 1);
    end
    check("lost_state", fsm_state, ST_LOST);

    // Centre back to 2000: averages 500, 1000, 1500 -> 010 on the 3rd sample
    set_in(12'd0, 12'd2000, 12'd0);
    wait_valid(cyc);
    wait_valid(cyc);
    check("relock_s2_lost", line_lost, 1);
    wait_valid(cyc);
    check("relock_s3_lost", line_lost, 0);
    check("relock_s3_pattern", line_pattern, 3'b010);
    repeat (2) wait_valid(cyc);

    // Exactly 15 zeros then 010 must not raise line_lost
    set_in(12'd0, 12'd0, 12'd0);
    lost_seen = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      wait_valid(cyc);
      lost_seen = lost_seen | line_lost;
    end
    center_value = 12'd4095;
    wait_valid(cyc);
    lost_seen = lost_seen | line_lost;
    check("z15_s16_pattern", line_pattern, 3'b000);
    wait_valid(cyc);
    lost_seen = lost_seen | line_lost;
    check("z15_s17_pattern", line_pattern, 3'b010);
    check("z15_never_lost", lost_seen, 0);

    // Fresh reset, then left=500 centre=1400 right=2500
    reset = 1'b1;
    set_in(12'd500, 12'd1400, 12'd2500);
    repeat (2) @(negedge clk_50M);
    reset = 1'b0;
    wait_valid(cyc);
    check("pos_pattern", line_pattern, 3'b001);
    check("pos_error", position_error, 2000);

    // Hysteresis on centre: 1600 sets at avg 1500 (2nd sample)
    center_value = 12'd1600;
    wait_valid(cyc);
    check("hy_up_s1", line_pattern, 3'b001);
    wait_valid(cyc);
    check("hy_up_s2", line_pattern, 3'b011);
    repeat (2) wait_valid(cyc);
    center_value = 12'd1400;
    repeat (4) wait_valid(cyc);
    check("hy_hold_1400", line_pattern, 3'b011);
    center_value = 12'd1200;
    wait_valid(cyc);
    wait_valid(cyc);
    check("hy_avg_1300_holds", line_pattern, 3'b011);
    wait_valid(cyc);
    check("hy_avg_1250_clears", line_pattern, 3'b001);
    wait_valid(cyc);

    // Extreme negative error
    set_in(12'd4095, 12'd1200, 12'd0);
    repeat (4) wait_valid(cyc);
    check("neg_error", position_error, -4095);
    check("neg_pattern", line_pattern, 3'b100);

    // 300 node passes; one pulse each, count saturates at 255
    bad_reps = 0;
    for (int rep = 0; rep < 300; rep++) begin
      pulses = 0;
      set_in(12'd2000, 12'd2000, 12'd2000);
      repeat (7) begin
        wait_valid(cyc);
        if (node_detected) pulses++;
      end
      set_in(12'd0, 12'd2000, 12'd0);
      repeat (3) begin
        wait_valid(cyc);
        if (node_detected) pulses++;
      end
      if (pulses != 1) bad_reps++;
      if (rep == 0) check("sat_first_count", node_count, 1);
    end
    check("sat_one_pulse_each", bad_reps, 0);
    check("sat_count", node_count, 255);
    check("sat_state", fsm_state, ST_FOLLOW);

    // Toggle left every clock across two ticks: no capture until it settles, then one
    toggled_valids = 0;
    for (int i = 0; i < 36; i++) begin
      left_value = (i % 2 == 0) ? 12'd4095 : 12'd0;
      @(negedge clk_50M);
      if (sample_valid) toggled_valids++;
    end
    check("toggle_no_capture", toggled_valids, 0);
    win = 0;
    repeat (8) begin
      @(negedge clk_50M);
      if (sample_valid) win++;
    end
    check("toggle_merged_capture", win, 1);

    // Reset mid-operation clears everything on the next edge
    check("pre_reset_count", node_count, 255);
    reset = 1'b1;
    @(negedge clk_50M);
    check_all_zero("midreset");
    set_in(12'd2000, 12'd2000, 12'd2000);
    @(negedge clk_50M);
    reset = 1'b0;
    wait_valid(cyc);
    check("post_reset_latency", cyc, 65);
    check("post_reset_pattern", line_pattern, 3'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
